fifo_to_in_fm_bank: RTL and testbench

Receiving end of the `ram_to_fifo` push interface for the input feature map. It buffers words pushed from external memory and drains one tile of Tm×Tr×Tc words, stored in channel-major order, into X parallel on-chip input_fm banks. Each channel is placed in bank `m mod X`. The block sits inside the conv core between the in_fm load path and the compute datapath.

---
 rtl/fifo_to_in_fm_bank_pkg.sv | 47 ++++
 rtl/fifo_to_in_fm_bank_push.sv | 95 +++++++++
 rtl/fifo_to_in_fm_bank.sv | 164 ++++++++++++++++
 tb/tb_fifo_to_in_fm_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_to_in_fm_bank_pkg.sv
// Shared types and elaboration helpers for the input feature-map bank loader.
// The tile geometry helpers are evaluated with the parameters of each instance.
package fifo_to_in_fm_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input longint unsigned n);
        int               bits;
        longint unsigned  span;
        bits = 0;
        span = 1;
        while (span < n) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

    // Bits needed to hold an index 0..n-1, never less than one.
    function automatic int width_of(input longint unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic longint unsigned tile_words(input int tm, input int tr, input int tc);
        return longint'(tm) * longint'(tr) * longint'(tc);
    endfunction

    function automatic longint unsigned bank_words(input int tm, input int tr, input int tc,
                                                   input int x);
        return longint'(tm / x) * longint'(tr) * longint'(tc);
    endfunction

    localparam int DEF_TM = 16;
    localparam int DEF_TR = 64;
    localparam int DEF_TC = 16;
    localparam int DEF_X  = 4;

    localparam longint unsigned TILE_WORDS = tile_words(DEF_TM, DEF_TR, DEF_TC);
    localparam longint unsigned BANK_WORDS = bank_words(DEF_TM, DEF_TR, DEF_TC, DEF_X);

endpackage

// File: rtl/fifo_to_in_fm_bank_push.sv
// Synchronous FIFO on the receive side of the ram_to_fifo push interface.
// Read data is registered: a pop in cycle t presents its word in cycle t+1.
module push_fifo
    import fifo_to_in_fm_bank_pkg::*;
#(
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DW-1:0]                 data,
    input  logic                          pop,
    output logic [DW-1:0]                 rd_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("push_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_MARGIN < 4) || (AF_MARGIN >= DEPTH)) begin : g_bad_margin
        $error("push_fifo: AF_MARGIN must be at least 4 and below DEPTH");
    end

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             bypass;
    logic             do_pop;
    logic             do_push;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Push and pop on an empty FIFO hands the word straight to the read register.
    assign bypass  = push && pop && empty;
    assign do_pop  = pop && !empty;
    assign do_push = push && !bypass && (!full || do_pop);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_data     <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count       <= count_d;
            almost_full <= (count_d >= AF_CNT);
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (bypass) begin
                rd_data <= data;
            end else if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/fifo_to_in_fm_bank.sv
// Drains one Tm x Tr x Tc input feature-map tile from the push FIFO into X banks,
// channel m landing in bank m mod X, with addresses built incrementally.
module fifo_to_in_fm_bank
    import fifo_to_in_fm_bank_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int Tm        = 16,
    parameter int Tr        = 64,
    parameter int Tc        = 16,
    parameter int X         = 4,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    input  logic          fifo_push,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_almost_full,
    output logic          overflow,
    output logic [X-1:0]  bank_wena,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_data
);

    localparam longint unsigned TILE_LEN = tile_words(Tm, Tr, Tc);
    localparam longint unsigned BANK_LEN = bank_words(Tm, Tr, Tc, X);
    localparam int WCW = clog2(TILE_LEN + 1);
    localparam int CW  = width_of(Tc);
    localparam int RW  = width_of(Tr);
    localparam int BW  = width_of(X);
    localparam int FCW = clog2(DEPTH + 1);

    localparam logic [WCW-1:0] LAST_WORD  = WCW'(TILE_LEN - 1);
    localparam logic [CW-1:0]  C_LAST     = CW'(Tc - 1);
    localparam logic [RW-1:0]  R_LAST     = RW'(Tr - 1);
    localparam logic [BW-1:0]  B_LAST     = BW'(X - 1);
    localparam logic [AW-1:0]  ROW_STEP   = AW'(Tc);
    localparam logic [AW-1:0]  PLANE_STEP = AW'(longint'(Tr) * longint'(Tc));
    localparam logic [X-1:0]   WENA0      = X'(1);

    if ((Tm % X) != 0) begin : g_bad_banks
        $error("fifo_to_in_fm_bank: Tm must be a multiple of X");
    end
    if ((AW < 63) && (BANK_LEN >= (64'd1 << AW))) begin : g_bad_aw
        $error("fifo_to_in_fm_bank: per-bank word count does not fit in AW bits");
    end

    state_t           state_q;
    state_t           state_d;
    logic             pop;
    logic             clear;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FCW-1:0]   fifo_count;
    logic             unused_fifo_status;

    logic [WCW-1:0]   word_cnt;
    logic [CW-1:0]    c;
    logic [RW-1:0]    r;
    logic [BW-1:0]    b;
    logic [AW-1:0]    racc;
    logic [AW-1:0]    base;

    push_fifo #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_push_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .data        (fifo_data),
        .pop         (pop),
        .rd_data     (bank_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (fifo_almost_full),
        .overflow    (overflow),
        .count       (fifo_count)
    );

    assign unused_fifo_status = ^{fifo_full, fifo_count};

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        clear   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write strobe and address are registered on the pop edge, matching the FIFO read register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_cnt  <= '0;
            c         <= '0;
            r         <= '0;
            b         <= '0;
            racc      <= '0;
            base      <= '0;
            bank_wena <= '0;
            bank_addr <= '0;
        end else begin
            state_q   <= state_d;
            bank_wena <= '0;
            if (clear) begin
                word_cnt <= '0;
                c        <= '0;
                r        <= '0;
                b        <= '0;
                racc     <= '0;
                base     <= '0;
            end else if (pop) begin
                bank_wena <= WENA0 << b;
                bank_addr <= base + racc + AW'(c);
                word_cnt  <= word_cnt + WCW'(1);
                if (c == C_LAST) begin
                    c <= '0;
                    if (r == R_LAST) begin
                        r    <= '0;
                        racc <= '0;
                        if (b == B_LAST) begin
                            b    <= '0;
                            base <= base + PLANE_STEP;
                        end else begin
                            b <= b + BW'(1);
                        end
                    end else begin
                        r    <= r + RW'(1);
                        racc <= racc + ROW_STEP;
                    end
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_to_in_fm_bank.sv
// Scoreboard bench: the driver queues the expected bank write for every accepted
// tile word, and a negedge monitor pops and compares each observed write.
module tb_fifo_to_in_fm_bank;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int TM        = 16;
    localparam int TR        = 64;
    localparam int TC        = 16;
    localparam int X         = 4;
    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 4;
    localparam int PLANE     = TR * TC;
    localparam int TILE      = TM * PLANE;

    typedef struct packed {
        logic [X-1:0]  wena;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          fifo_push = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          done;
    logic          fifo_almost_full;
    logic          overflow;
    logic [X-1:0]  bank_wena;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_data;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  writes_seen = 0;
    int  done_seen = 0;
    int  widx = 0;

    fifo_to_in_fm_bank #(
        .AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC), .X(X),
        .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .done             (done),
        .fifo_push        (fifo_push),
        .fifo_data        (fifo_data),
        .fifo_almost_full (fifo_almost_full),
        .overflow         (overflow),
        .bank_wena        (bank_wena),
        .bank_addr        (bank_addr),
        .bank_data        (bank_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word idx of a tile belongs to channel idx / (Tr*Tc); that channel sits in
    // bank (channel mod X) at row base (channel / X) * Tr*Tc.
    function automatic wr_t expect_write(input int idx, input logic [DW-1:0] d);
        wr_t w;
        int  m;
        m      = idx / PLANE;
        w.wena = X'(1) << (m % X);
        w.addr = AW'((m / X) * PLANE + (idx % PLANE));
        w.data = d;
        return w;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (bank_wena !== '0 && rst === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bank_wena), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_wena", 64'(bank_wena), 64'(e.wena));
                check("wr_addr", 64'(bank_addr), 64'(e.addr));
                check("wr_data", 64'(bank_data), 64'(e.data));
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        bit sent;
        sent = 1'b0;
        while (!sent) begin
            if (!fifo_almost_full && $urandom_range(7) != 0) begin
                fifo_push = 1'b1;
                fifo_data = d;
                exp_q.push_back(expect_write(widx, d));
                widx++;
                sent = 1'b1;
            end
            @(negedge clk);
            fifo_push = 1'b0;
        end
    endtask

    // start and the first tile word in the same cycle
    task automatic begin_tile(input logic [DW-1:0] d);
        widx      = 0;
        start     = 1'b1;
        fifo_push = 1'b1;
        fifo_data = d;
        exp_q.push_back(expect_write(widx, d));
        widx++;
        @(negedge clk);
        start     = 1'b0;
        fifo_push = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 400 && done_seen < target; k++) @(negedge clk);
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;

        // Reset held with pushes active: outputs stay zero, pushes are dropped.
        rst       = 1'b0;
        fifo_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fifo_data = $urandom;
            @(negedge clk);
            check("rst_ctrl", 64'({done, fifo_almost_full, overflow, bank_wena}), 64'd0);
            check("rst_addr", 64'(bank_addr), 64'd0);
            check("rst_data", 64'(bank_data), 64'd0);
        end
        fifo_push = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Fill without start: almost_full at 12 proves the FIFO began empty; 17th push overflows.
        for (int k = 1; k <= DEPTH + 1; k++) begin
            fifo_push = 1'b1;
            fifo_data = $urandom;
            @(negedge clk);
            check($sformatf("af_after_%0d", k), 64'(fifo_almost_full),
                  64'(k >= DEPTH - AF_MARGIN));
            check($sformatf("ovf_after_%0d", k), 64'(overflow), 64'(k > DEPTH));
            check("idle_no_write", 64'(bank_wena), 64'd0);
        end
        fifo_push = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_sticky", 64'(overflow), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("ovf_cleared", 64'({overflow, fifo_almost_full}), 64'd0);

        // Tile 1: data = word index; first word checks the push-to-write latency.
        begin_tile('0);
        check("latency_t1_wena", 64'(bank_wena), 64'd0);
        @(negedge clk);
        check("latency_t2_wena", 64'(bank_wena), 64'd1);
        check("latency_t2_addr", 64'(bank_addr), 64'd0);
        while (widx < TILE) begin
            if (widx == 100) start = 1'b1;
            push_word(DW'(widx));
            start = 1'b0;
        end
        wait_done(1);
        check("tile1_done", 64'(done_seen), 64'd1);
        repeat (5) @(negedge clk);
        check("tile1_done_once", 64'(done_seen), 64'd1);
        check("tile1_writes", 64'(writes_seen), 64'(TILE));
        check("tile1_sb_empty", 64'(exp_q.size()), 64'd0);
        check("tile1_no_ovf", 64'(overflow), 64'd0);

        // Tile 2 aborted by reset after 500 writes.
        wr0 = writes_seen;
        begin_tile($urandom);
        while (writes_seen - wr0 < 500) push_word($urandom);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("abort_wena", 64'(bank_wena), 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'd1);
        check("abort_no_write", 64'(bank_wena), 64'd0);

        // Tile 3: full restart with random data; must begin at word 0, bank 0, addr 0.
        wr0 = writes_seen;
        begin_tile($urandom);
        while (widx < TILE) push_word($urandom);
        wait_done(2);
        repeat (5) @(negedge clk);
        check("tile3_done", 64'(done_seen), 64'd2);
        check("tile3_writes", 64'(writes_seen - wr0), 64'(TILE));
        check("tile3_sb_empty", 64'(exp_q.size()), 64'd0);
        check("tile3_no_ovf", 64'(overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
